// File: rtl/sprite_draw_arbiter_pkg.sv
// sprite_draw_arbiter_pkg: shared FSM encoding, screen/sprite limits and pixel coordinate type.
package sprite_draw_arbiter_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARB   = 3'd1;
    localparam logic [2:0] S_SCAN  = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int SPR_W    = 20;
    localparam int SPR_H    = 20;

    localparam logic [8:0] TRANSP = 9'h1FF;

    // Untruncated screen coordinate, one bit wider than the VGA port so off-screen sums are visible.
    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
    } coord_t;

    function automatic logic on_screen(input coord_t c);
        return c.x < 9'(SCREEN_W) && c.y < 8'(SCREEN_H);
    endfunction

endpackage

// File: rtl/sprite_draw_arbiter_rr.sv
// rr_arbiter: picks the first requester at or after the pointer, returning one-hot and index forms.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = N > 1 ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx
);

    logic [N-1:0] w_rot;

    assign w_rot = N'({i_req, i_req} >> i_ptr);

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        for (int k = N - 1; k >= 0; k--)
            if (w_rot[k]) begin
                o_gnt = N'(1) << ((int'(i_ptr) + k) % N);
                o_idx = IW'((int'(i_ptr) + k) % N);
            end
    end

endmodule

// File: rtl/sprite_draw_arbiter.sv
// sprite_draw_arbiter: round-robin grants one requester at a time and streams its sprite from ROM to VGA.
module sprite_draw_arbiter
    import sprite_draw_arbiter_pkg::*;
#(
    parameter int         NUM_REQ     = 4,
    parameter int         SPRITE_W    = SPR_W,
    parameter int         SPRITE_H    = SPR_H,
    parameter logic [8:0] TRANSPARENT = TRANSP
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] req_x,
    input  logic [NUM_REQ*7-1:0] req_y,
    input  logic [NUM_REQ*2-1:0] req_sel,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic [1:0]           rom_sel,
    output logic [8:0]           rom_addr,
    input  logic [8:0]           rom_q,
    output logic [7:0]           vga_x,
    output logic [6:0]           vga_y,
    output logic [8:0]           vga_colour,
    output logic                 vga_plot,
    output logic                 busy
);

    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int CW = SPRITE_W > 1 ? $clog2(SPRITE_W) : 1;
    localparam int RW = SPRITE_H > 1 ? $clog2(SPRITE_H) : 1;

    logic [2:0]         r_state;
    logic [IW-1:0]      r_ptr, r_win, w_idx;
    logic [NUM_REQ-1:0] r_win_oh, w_onehot;
    logic [7:0]         r_ox;
    logic [6:0]         r_oy;
    logic [CW-1:0]      r_col;
    logic [RW-1:0]      r_row;
    logic               r_v0, r_v1, r_fl;
    coord_t             w_c0, r_c1;
    logic               w_last;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
        .i_req(req),
        .i_ptr(r_ptr),
        .o_gnt(w_onehot),
        .o_idx(w_idx)
    );

    assign w_c0.x = {1'b0, r_ox} + 9'(r_col);
    assign w_c0.y = {1'b0, r_oy} + 8'(r_row);
    assign w_last = r_col == CW'(SPRITE_W - 1) && r_row == RW'(SPRITE_H - 1);
    assign busy   = r_state != S_IDLE;

    // The winner is frozen on leaving IDLE so a requester dropping req during ARB still gets its draw.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_win      <= '0;
            r_win_oh   <= '0;
            r_ox       <= '0;
            r_oy       <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_v0       <= 1'b0;
            r_v1       <= 1'b0;
            r_fl       <= 1'b0;
            r_c1       <= '0;
            gnt        <= '0;
            done       <= '0;
            rom_sel    <= '0;
            rom_addr   <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else begin
            done     <= '0;
            r_v1     <= r_v0;
            r_c1     <= w_c0;
            vga_plot <= r_v1 && rom_q != TRANSPARENT && on_screen(r_c1);
            if (r_v1) begin
                vga_x      <= r_c1.x[7:0];
                vga_y      <= r_c1.y[6:0];
                vga_colour <= rom_q;
            end
            case (r_state)
                S_IDLE:
                    if (|req) begin
                        r_state  <= S_ARB;
                        r_win    <= w_idx;
                        r_win_oh <= w_onehot;
                    end
                S_ARB: begin
                    r_state  <= S_SCAN;
                    gnt      <= r_win_oh;
                    r_ox     <= req_x[int'(r_win) * 8 +: 8];
                    r_oy     <= req_y[int'(r_win) * 7 +: 7];
                    rom_sel  <= req_sel[int'(r_win) * 2 +: 2];
                    r_col    <= '0;
                    r_row    <= '0;
                    rom_addr <= '0;
                    r_v0     <= 1'b1;
                    r_fl     <= 1'b0;
                end
                S_SCAN:
                    if (w_last) begin
                        r_v0    <= 1'b0;
                        r_state <= S_FLUSH;
                    end else begin
                        rom_addr <= rom_addr + 9'd1;
                        r_col    <= r_col == CW'(SPRITE_W - 1) ? '0 : r_col + 1'b1;
                        r_row    <= r_col == CW'(SPRITE_W - 1) ? r_row + 1'b1 : r_row;
                    end
                S_FLUSH: begin
                    r_fl    <= 1'b1;
                    r_state <= r_fl ? S_DONE : S_FLUSH;
                end
                S_DONE: begin
                    done    <= gnt;
                    gnt     <= '0;
                    r_ptr   <= int'(r_win) == NUM_REQ - 1 ? '0 : r_win + 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_draw_arbiter.sv
// tb_sprite_draw_arbiter: randomized scenarios checked against a per-pixel sprite model and a round-robin pointer model.
module tb_sprite_draw_arbiter;

    localparam int N = 4, W = 20, H = 20, NPIX = W * H, LAT = NPIX + 3;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*8-1:0] req_x = '0;
    logic [N*7-1:0] req_y = '0;
    logic [N*2-1:0] req_sel = '0;
    logic [N-1:0]   gnt, done;
    logic [1:0]     rom_sel;
    logic [8:0]     rom_addr;
    logic [8:0]     rom_q = '0;
    logic [7:0]     vga_x;
    logic [6:0]     vga_y;
    logic [8:0]     vga_colour;
    logic           vga_plot, busy;

    logic [8:0]  rom [4][NPIX];
    logic [23:0] plots[$], exp_q[$];
    int checks = 0, failures = 0, done_cnt = 0, oh_err = 0, m_ptr = 0;
    int m_ox[N], m_oy[N], m_sel[N];

    sprite_draw_arbiter dut (
        .clk(clk), .resetn(resetn), .req(req), .req_x(req_x), .req_y(req_y), .req_sel(req_sel),
        .gnt(gnt), .done(done), .rom_sel(rom_sel), .rom_addr(rom_addr), .rom_q(rom_q),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= rom[rom_sel][int'(rom_addr) < NPIX ? int'(rom_addr) : 0];

    always @(negedge clk) begin
        if (vga_plot) plots.push_back({vga_x, vga_y, vga_colour});
        if (|done) done_cnt++;
        if (!$onehot0(gnt)) oh_err++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int exp_winner(input logic [N-1:0] m);
        for (int k = 0; k < N; k++) if (m[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    // Sprite model: every ROM pixel, in raster order, that is opaque and lands on the 160x120 screen.
    function automatic void build_exp(input int i);
        int x, y;
        logic [8:0] c;
        exp_q.delete();
        for (int r = 0; r < H; r++)
            for (int cc = 0; cc < W; cc++) begin
                x = m_ox[i] + cc;
                y = m_oy[i] + r;
                c = rom[m_sel[i]][r * W + cc];
                if (c != 9'h1FF && x < 160 && y < 120) exp_q.push_back({x[7:0], y[6:0], c});
            end
    endfunction

    function automatic int pix_diff();
        int d;
        d = plots.size() > exp_q.size() ? plots.size() - exp_q.size() : exp_q.size() - plots.size();
        for (int i = 0; i < plots.size() && i < exp_q.size(); i++) if (plots[i] !== exp_q[i]) d++;
        return d;
    endfunction

    task automatic set_req(input int i, input int ox, input int oy, input int sel);
        req_x[i*8 +: 8]   = 8'(ox);
        req_y[i*7 +: 7]   = 7'(oy);
        req_sel[i*2 +: 2] = 2'(sel);
        m_ox[i] = ox;
        m_oy[i] = oy;
        m_sel[i] = sel;
    endtask

    task automatic run_draw(output int who, output int lat);
        int n;
        who = -1;
        lat = -1;
        n = 0;
        while (gnt == '0 && n < 20) begin @(negedge clk); n++; end
        if (gnt == '0) return;
        for (int i = 0; i < N; i++) if (gnt[i]) who = i;
        lat = 0;
        while (!done[who] && lat < 1000) begin @(negedge clk); lat++; end
        req[who] = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({gnt, done, busy, vga_plot} !== '0)
            begin failures++; $display("FAIL reset_ctrl: gnt/done/busy/plot=%b expected 0", {gnt, done, busy, vga_plot}); end
        checks++;
        if ({rom_addr, rom_sel, vga_x, vga_y, vga_colour} !== '0)
            begin failures++; $display("FAIL reset_data: addr=%0d sel=%0d x=%0d y=%0d c=%h expected 0", rom_addr, rom_sel, vga_x, vga_y, vga_colour); end
    endtask

    task automatic test_single();
        int who, lat, mnx, mxx, mny, mxy;
        set_req(0, 10, 20, 0);
        build_exp(0);
        plots.delete();
        req = 4'b0001;
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt !== '0 || busy !== 1'b1)
            begin failures++; $display("FAIL first_edge: gnt=%b busy=%b expected gnt=0000 busy=1", gnt, busy); end
        run_draw(who, lat);
        m_ptr = 1;
        checks++;
        if (who != 0) begin failures++; $display("FAIL single_who: got %0d expected 0", who); end
        checks++;
        if (lat != LAT) begin failures++; $display("FAIL single_lat: got %0d expected %0d", lat, LAT); end
        checks++;
        if (plots.size() != 400) begin failures++; $display("FAIL single_count: got %0d expected 400", plots.size()); end
        mnx = 255; mxx = 0; mny = 127; mxy = 0;
        foreach (plots[i]) begin
            mnx = int'(plots[i][23:16]) < mnx ? int'(plots[i][23:16]) : mnx;
            mxx = int'(plots[i][23:16]) > mxx ? int'(plots[i][23:16]) : mxx;
            mny = int'(plots[i][15:9]) < mny ? int'(plots[i][15:9]) : mny;
            mxy = int'(plots[i][15:9]) > mxy ? int'(plots[i][15:9]) : mxy;
        end
        checks++;
        if (mnx != 10 || mxx != 29 || mny != 20 || mxy != 39)
            begin failures++; $display("FAIL single_bbox: x %0d..%0d y %0d..%0d expected x 10..29 y 20..39", mnx, mxx, mny, mxy); end
        checks++;
        if (pix_diff() != 0) begin failures++; $display("FAIL single_pixels: %0d differences expected 0", pix_diff()); end
    endtask

    task automatic test_transparent();
        int who, lat, ox, oy, hits;
        ox = $urandom_range(0, 140);
        oy = $urandom_range(0, 100);
        set_req(1, ox, oy, 1);
        build_exp(1);
        plots.delete();
        req = 4'b0010;
        run_draw(who, lat);
        m_ptr = 2;
        checks++;
        if (who != 1 || lat != LAT) begin failures++; $display("FAIL transp_draw: who=%0d lat=%0d expected 1/%0d", who, lat, LAT); end
        checks++;
        if (plots.size() != 399) begin failures++; $display("FAIL transp_count: got %0d expected 399", plots.size()); end
        hits = 0;
        foreach (plots[i]) if (int'(plots[i][23:16]) == ox + 1 && int'(plots[i][15:9]) == oy + 1) hits++;
        checks++;
        if (hits != 0) begin failures++; $display("FAIL transp_hole: %0d plots at (ox+1,oy+1) expected 0", hits); end
        checks++;
        if (pix_diff() != 0) begin failures++; $display("FAIL transp_pixels: %0d differences expected 0", pix_diff()); end
    endtask

    task automatic test_clip();
        int who, lat;
        set_req(3, 150, 110, 0);
        build_exp(3);
        plots.delete();
        req = 4'b1000;
        run_draw(who, lat);
        m_ptr = 0;
        checks++;
        if (who != 3 || lat != LAT) begin failures++; $display("FAIL clip_draw: who=%0d lat=%0d expected 3/%0d", who, lat, LAT); end
        checks++;
        if (plots.size() != 100) begin failures++; $display("FAIL clip_count: got %0d expected 100", plots.size()); end
        checks++;
        if (pix_diff() != 0) begin failures++; $display("FAIL clip_pixels: %0d differences expected 0", pix_diff()); end
    endtask

    task automatic test_round_robin();
        int who, lat;
        for (int rnd = 0; rnd < 2; rnd++) begin
            for (int i = 0; i < N; i++) set_req(i, $urandom_range(0, 170), $urandom_range(0, 125), $urandom_range(0, 3));
            req = '1;
            for (int k = 0; k < N; k++) begin
                build_exp(k);
                plots.delete();
                run_draw(who, lat);
                m_ptr = (k + 1) % N;
                checks++;
                if (who != k) begin failures++; $display("FAIL rr_order: round %0d slot %0d got %0d expected %0d", rnd, k, who, k); end
                checks++;
                if (lat != LAT) begin failures++; $display("FAIL rr_lat: got %0d expected %0d", lat, LAT); end
                checks++;
                if (pix_diff() != 0) begin failures++; $display("FAIL rr_pixels: requester %0d %0d differences expected 0", k, pix_diff()); end
            end
        end
        checks++;
        if (oh_err != 0) begin failures++; $display("FAIL gnt_onehot: %0d cycles with multiple grants expected 0", oh_err); end
    endtask

    task automatic test_drop_in_arb();
        int who, lat;
        set_req(2, $urandom_range(0, 150), $urandom_range(0, 110), $urandom_range(0, 3));
        build_exp(2);
        plots.delete();
        req = 4'b0100;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || gnt !== '0) begin failures++; $display("FAIL drop_arb_state: busy=%b gnt=%b expected 1/0000", busy, gnt); end
        req[2] = 1'b0;
        run_draw(who, lat);
        m_ptr = 3;
        checks++;
        if (who != 2 || lat != LAT) begin failures++; $display("FAIL drop_draw: who=%0d lat=%0d expected 2/%0d", who, lat, LAT); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL drop_busy: busy=%b after done expected 0", busy); end
        checks++;
        if (pix_diff() != 0) begin failures++; $display("FAIL drop_pixels: %0d differences expected 0", pix_diff()); end
    endtask

    task automatic test_reset_mid_scan();
        int who, lat, n, d0;
        set_req(1, $urandom_range(0, 150), $urandom_range(0, 110), $urandom_range(0, 3));
        req = 4'b0010;
        n = 0;
        while (gnt == '0 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (gnt !== 4'b0010) begin failures++; $display("FAIL abort_gnt: gnt=%b expected 0010", gnt); end
        repeat (200) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL abort_scanning: busy=%b expected 1", busy); end
        d0 = done_cnt;
        resetn = 1'b0;
        #1;
        checks++;
        if ({gnt, done, busy, vga_plot, rom_addr, rom_sel, vga_x, vga_y, vga_colour} !== '0)
            begin failures++; $display("FAIL abort_outputs: gnt=%b busy=%b plot=%b addr=%0d x=%0d y=%0d expected all 0", gnt, busy, vga_plot, rom_addr, vga_x, vga_y); end
        req = '0;
        m_ptr = 0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (450) @(negedge clk);
        checks++;
        if (done_cnt != d0 || busy !== 1'b0) begin failures++; $display("FAIL abort_no_done: done pulses %0d busy=%b expected 0/0", done_cnt - d0, busy); end
        for (int i = 0; i < N; i++) set_req(i, $urandom_range(0, 170), $urandom_range(0, 125), $urandom_range(0, 3));
        build_exp(0);
        plots.delete();
        req = '1;
        run_draw(who, lat);
        req = '0;
        m_ptr = 1;
        checks++;
        if (who != 0 || lat != LAT) begin failures++; $display("FAIL abort_next: who=%0d lat=%0d expected 0/%0d", who, lat, LAT); end
        checks++;
        if (pix_diff() != 0) begin failures++; $display("FAIL abort_pixels: %0d differences expected 0", pix_diff()); end
    endtask

    task automatic test_random();
        int who, lat, e;
        logic [N-1:0] mask;
        repeat (5) begin
            mask = N'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) if (mask[i]) set_req(i, $urandom_range(0, 170), $urandom_range(0, 125), $urandom_range(0, 3));
            e = exp_winner(mask);
            build_exp(e);
            plots.delete();
            req = mask;
            run_draw(who, lat);
            req = '0;
            m_ptr = (e + 1) % N;
            checks++;
            if (who != e) begin failures++; $display("FAIL rand_who: mask=%b got %0d expected %0d", mask, who, e); end
            checks++;
            if (lat != LAT) begin failures++; $display("FAIL rand_lat: got %0d expected %0d", lat, LAT); end
            checks++;
            if (pix_diff() != 0) begin failures++; $display("FAIL rand_pixels: %0d differences expected 0", pix_diff()); end
        end
    endtask

    initial begin
        for (int i = 0; i < NPIX; i++) begin
            rom[0][i] = 9'($urandom_range(0, 510));
            rom[1][i] = rom[0][i];
            rom[2][i] = $urandom_range(0, 7) == 0 ? 9'h1FF : 9'($urandom_range(0, 510));
            rom[3][i] = $urandom_range(0, 7) == 0 ? 9'h1FF : 9'($urandom_range(0, 510));
        end
        rom[1][21] = 9'h1FF;
        test_reset();
        test_single();
        test_transparent();
        test_clip();
        test_round_robin();
        test_drop_in_arb();
        test_reset_mid_scan();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
